fb_write_sequencer: RTL and testbench



---
 rtl/fb_pkg.sv | 21 ++
 rtl/fb_addr_calc.sv | 49 ++++
 rtl/fb_write_sequencer.sv | 116 +++++++++++
 tb/tb_fb_write_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: write-sequencer states, coordinate width,
// default screen geometry and a width helper used by the write path.
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } fb_wr_state_t;

    localparam int FB_COORD_W  = 32;
    localparam int FB_SCREEN_W = 160;
    localparam int FB_SCREEN_H = 120;

    // Bits needed to index n items, never less than one.
    function automatic int fb_width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Registered pixel-to-RAM write stage: linear address y*SCREEN_W + x.
// Define FB_WR_CLIP_EN to discard pixels outside the screen instead of wrapping.
module fb_addr_calc
    import fb_pkg::*;
#(
    parameter int COLOR_DEPTH = 9,
    parameter int SCREEN_W    = FB_SCREEN_W,
    parameter int SCREEN_H    = FB_SCREEN_H,
    parameter int ADDR_W      = fb_width_for(SCREEN_W * SCREEN_H)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   accept,
    input  logic [FB_COORD_W-1:0]  x,
    input  logic [FB_COORD_W-1:0]  y,
    input  logic [COLOR_DEPTH-1:0] color,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [COLOR_DEPTH-1:0] mem_wdata
);

    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SCREEN_W);

    logic [ADDR_W-1:0] lin_addr;
    logic              in_range;

    assign lin_addr = y[ADDR_W-1:0] * ROW_STRIDE + x[ADDR_W-1:0];

`ifdef FB_WR_CLIP_EN
    assign in_range = (x < FB_COORD_W'(SCREEN_W)) && (y < FB_COORD_W'(SCREEN_H));
`else
    assign in_range = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= accept && in_range;
            if (accept && in_range) begin
                mem_addr  <= lin_addr;
                mem_wdata <= color;
            end
        end
    end

endmodule

// File: rtl/fb_write_sequencer.sv
// Grants the frame-buffer write bus to each drawing source in turn and swaps
// buffers on frame once all sources are done. FB_WR_CLIP_EN enables clipping.
module fb_write_sequencer
    import fb_pkg::*;
#(
    parameter int MAX_WRITE_SOURCE = 1,
    parameter int COLOR_DEPTH      = 9,
    parameter int SCREEN_W         = FB_SCREEN_W,
    parameter int SCREEN_H         = FB_SCREEN_H,
    parameter int GRANT_TIMEOUT    = 16,
    parameter int SEL_W            = fb_width_for(MAX_WRITE_SOURCE + 1),
    parameter int ADDR_W           = fb_width_for(SCREEN_W * SCREEN_H)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame,
    input  logic [COLOR_DEPTH-1:0] write_color_data,
    input  logic [FB_COORD_W-1:0]  write_x_addr,
    input  logic [FB_COORD_W-1:0]  write_y_addr,
    input  logic                   write_active,
    output logic                   write_awaited,
    output logic [SEL_W-1:0]       write_source_sel,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [COLOR_DEPTH-1:0] mem_wdata,
    output logic                   back_buf,
    output logic                   busy,
    output logic [7:0]             overrun_count,
    output fb_wr_state_t           dbg_state
);

    localparam int TMO_W = fb_width_for(GRANT_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GRANT_TIMEOUT - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(MAX_WRITE_SOURCE);

    fb_wr_state_t     state;
    logic [TMO_W-1:0] idle_cnt;
    logic             accept;

    // Handshake: write_awaited acts as ready, write_active as valid; a pixel
    // transfers on every edge where both are high, and only then.
    assign accept    = write_awaited && write_active;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            write_source_sel <= '0;
            write_awaited    <= 1'b0;
            busy             <= 1'b0;
            back_buf         <= 1'b0;
            overrun_count    <= '0;
            idle_cnt         <= '0;
        end else begin
            if (frame && busy && overrun_count != 8'hFF)
                overrun_count <= overrun_count + 8'd1;

            case (state)
                ST_IDLE: begin
                    if (frame) begin
                        state            <= ST_GRANT;
                        write_source_sel <= '0;
                        write_awaited    <= 1'b1;
                        busy             <= 1'b1;
                        idle_cnt         <= '0;
                    end
                end
                ST_GRANT, ST_STREAM: begin
                    if (write_active) begin
                        state <= ST_STREAM;
                    end else if (state == ST_GRANT && idle_cnt != TMO_LAST) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end else if (write_source_sel == SEL_LAST) begin
                        // Source finished (stream gap) or timed out: advance or finish.
                        state         <= ST_DONE;
                        write_awaited <= 1'b0;
                        busy          <= 1'b0;
                    end else begin
                        state            <= ST_GRANT;
                        write_source_sel <= write_source_sel + 1'b1;
                        idle_cnt         <= '0;
                    end
                end
                ST_DONE: begin
                    if (frame) begin
                        state            <= ST_GRANT;
                        back_buf         <= ~back_buf;
                        write_source_sel <= '0;
                        write_awaited    <= 1'b1;
                        busy             <= 1'b1;
                        idle_cnt         <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fb_addr_calc #(
        .COLOR_DEPTH (COLOR_DEPTH),
        .SCREEN_W    (SCREEN_W),
        .SCREEN_H    (SCREEN_H),
        .ADDR_W      (ADDR_W)
    ) u_addr_calc (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept),
        .x         (write_x_addr),
        .y         (write_y_addr),
        .color     (write_color_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

endmodule

// File: tb/tb_fb_write_sequencer.sv
// Directed bench for fb_write_sequencer: grant order, write latency, timeout,
// buffer swap, overrun counting, clip/wrap and mid-stream reset.
module tb_fb_write_sequencer;
    import fb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame;
    logic [8:0]  write_color_data;
    logic [31:0] write_x_addr;
    logic [31:0] write_y_addr;
    logic        write_active;
    logic        write_awaited;
    logic [0:0]  write_source_sel;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [8:0]  mem_wdata;
    logic        back_buf;
    logic        busy;
    logic [7:0]  overrun_count;
    fb_wr_state_t dbg_state;

    int checks   = 0;
    int failures = 0;

    fb_write_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .frame            (frame),
        .write_color_data (write_color_data),
        .write_x_addr     (write_x_addr),
        .write_y_addr     (write_y_addr),
        .write_active     (write_active),
        .write_awaited    (write_awaited),
        .write_source_sel (write_source_sel),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .back_buf         (back_buf),
        .busy             (busy),
        .overrun_count    (overrun_count),
        .dbg_state        (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pixel(input logic act, input int x, input int y, input logic [8:0] c);
        write_active     = act;
        write_x_addr     = 32'(x);
        write_y_addr     = 32'(y);
        write_color_data = c;
    endtask

    initial begin
        reset = 1'b1;
        frame = 1'b0;
        drive_pixel(1'b0, 0, 0, 9'h0);
        tick();
        tick();
        check_eq("rst_awaited", 32'(write_awaited), 0);
        check_eq("rst_sel", 32'(write_source_sel), 0);
        check_eq("rst_we", 32'(mem_we), 0);
        check_eq("rst_addr", 32'(mem_addr), 0);
        check_eq("rst_wdata", 32'(mem_wdata), 0);
        check_eq("rst_back_buf", 32'(back_buf), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_overrun", 32'(overrun_count), 0);
        check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;

        // Activity while not awaited must not write.
        drive_pixel(1'b1, 7, 0, 9'h055);
        tick();
        check_eq("idle_ignore_we", 32'(mem_we), 0);
        check_eq("idle_ignore_state", 32'(dbg_state), 32'(ST_IDLE));
        drive_pixel(1'b0, 0, 0, 9'h0);

        frame = 1'b1;
        tick();
        frame = 1'b0;
        check_eq("grant0_sel", 32'(write_source_sel), 0);
        check_eq("grant0_awaited", 32'(write_awaited), 1);
        check_eq("grant0_busy", 32'(busy), 1);
        check_eq("grant0_back_buf", 32'(back_buf), 0);

        for (int i = 0; i < 3; i++) begin
            drive_pixel(1'b1, i, 0, 9'(9'h010 + i));
            tick();
            check_eq("s0_we", 32'(mem_we), 1);
            check_eq("s0_addr", 32'(mem_addr), 32'(i));
            check_eq("s0_wdata", 32'(mem_wdata), 32'(9'h010 + i));
        end
        check_eq("s0_stream_state", 32'(dbg_state), 32'(ST_STREAM));

        drive_pixel(1'b1, 5, 2, 9'h1A5);
        tick();
        check_eq("xy_we", 32'(mem_we), 1);
        check_eq("xy_addr", 32'(mem_addr), 325);
        check_eq("xy_wdata", 32'(mem_wdata), 32'h1A5);

        drive_pixel(1'b1, 160, 0, 9'h033);
        tick();
`ifdef FB_WR_CLIP_EN
        check_eq("clip_we", 32'(mem_we), 0);
`else
        check_eq("wrap_we", 32'(mem_we), 1);
        check_eq("wrap_addr", 32'(mem_addr), 160);
`endif

        drive_pixel(1'b0, 0, 0, 9'h0);
        tick();
        check_eq("s0_end_we", 32'(mem_we), 0);
        check_eq("s1_sel", 32'(write_source_sel), 1);
        check_eq("s1_awaited", 32'(write_awaited), 1);
        check_eq("s1_state", 32'(dbg_state), 32'(ST_GRANT));

        for (int i = 0; i < 15; i++) tick();
        check_eq("s1_wait_state", 32'(dbg_state), 32'(ST_GRANT));
        tick();
        check_eq("tmo_state", 32'(dbg_state), 32'(ST_DONE));
        check_eq("tmo_awaited", 32'(write_awaited), 0);
        check_eq("tmo_busy", 32'(busy), 0);
        check_eq("tmo_sel", 32'(write_source_sel), 1);

        frame = 1'b1;
        tick();
        frame = 1'b0;
        check_eq("swap_back_buf", 32'(back_buf), 1);
        check_eq("swap_sel", 32'(write_source_sel), 0);
        check_eq("swap_awaited", 32'(write_awaited), 1);
        check_eq("swap_state", 32'(dbg_state), 32'(ST_GRANT));

        drive_pixel(1'b1, 1, 1, 9'h0A1);
        tick();
        check_eq("f2_p0_addr", 32'(mem_addr), 161);
        drive_pixel(1'b1, 2, 1, 9'h0A2);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        check_eq("ovr_count", 32'(overrun_count), 1);
        check_eq("ovr_back_buf", 32'(back_buf), 1);
        check_eq("ovr_state", 32'(dbg_state), 32'(ST_STREAM));
        check_eq("ovr_we", 32'(mem_we), 1);
        check_eq("ovr_addr", 32'(mem_addr), 162);
        drive_pixel(1'b1, 3, 1, 9'h0A3);
        tick();
        check_eq("ovr_cont_we", 32'(mem_we), 1);
        check_eq("ovr_cont_addr", 32'(mem_addr), 163);
        check_eq("ovr_cont_wdata", 32'(mem_wdata), 32'h0A3);

        // Reset with x=3 write pending on the bus and x=4 being presented.
        drive_pixel(1'b1, 4, 1, 9'h0A4);
        reset = 1'b1;
        tick();
        check_eq("mrst_we", 32'(mem_we), 0);
        check_eq("mrst_awaited", 32'(write_awaited), 0);
        check_eq("mrst_back_buf", 32'(back_buf), 0);
        check_eq("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("mrst_overrun", 32'(overrun_count), 0);
        check_eq("mrst_busy", 32'(busy), 0);
        reset = 1'b0;
        drive_pixel(1'b0, 0, 0, 9'h0);
        tick();
        check_eq("post_rst_we", 32'(mem_we), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
